// File: rtl/lsu_data_if.sv
// lsu_data_if
//   Load/store front-end between the core memory-request port and data_mem.
//   It takes one byte, half or word request at a time over a valid/ready
//   handshake and checks that the whole access lies inside the data_mem
//   window. It then drives the data_mem strobes for exactly one cycle and
//   returns the extended load data, or an error, over a valid/ready
//   response channel.
//
// Ports
//   clk_i, rst_i           clock; synchronous active-high reset
//   req_valid_i/ready_o    request handshake
//   req_we_i               1 = store, 0 = load
//   req_size_i             00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i         load zero-extends when 1, sign-extends when 0
//   req_addr_i             byte address (any alignment)
//   req_wdata_i            store data, low-justified
//   resp_valid_o/ready_i   response handshake
//   resp_rdata_o           extended load data (0 for stores and errors)
//   resp_err_o             request rejected, no memory access made
//   mem_write_o, mem_be_sel_o, mem_addr_o, mem_data_o   to data_mem
//   mem_data_i             from data_mem (combinational, address-relative lanes)
module lsu_data_if #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_write_o,
    output logic [3:0]  mem_be_sel_o,
    output logic [12:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        err_q;
    logic [12:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic [31:0] off;
    logic [31:0] nbytes;
    logic        acc_err;
    logic [31:0] load_ext;
    logic [3:0]  be;

    assign accept = req_valid_i & req_ready_o;

    // Offsets below BASE_ADDR wrap to huge values, so a single unsigned
    // compare against the last legal start offset covers both window ends.
    always_comb begin
        off    = req_addr_i - BASE_ADDR;
        nbytes = 32'd4;
        case (req_size_i)
            2'b00:   nbytes = 32'd1;
            2'b01:   nbytes = 32'd2;
            default: nbytes = 32'd4;
        endcase
        acc_err = (req_size_i == 2'b11) || (off > (32'd8192 - nbytes));
    end

    always_comb begin
        load_ext = '0;
        be       = '0;
        case (size_q)
            2'b00: begin
                load_ext = uns_q ? {24'h0, mem_data_i[7:0]}
                                 : {{24{mem_data_i[7]}}, mem_data_i[7:0]};
                be       = 4'b0001;
            end
            2'b01: begin
                load_ext = uns_q ? {16'h0, mem_data_i[15:0]}
                                 : {{16{mem_data_i[15]}}, mem_data_i[15:0]};
                be       = 4'b0011;
            end
            default: begin
                load_ext = mem_data_i;
                be       = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q   <= req_we_i;
                size_q <= req_size_i;
                uns_q  <= req_unsigned_i;
                err_q  <= acc_err;
                // Memory address/data lines only move for accesses that will
                // actually be performed; rejected requests leave them as-is.
                if (!acc_err) begin
                    addr_q  <= off[12:0];
                    wdata_q <= req_wdata_i;
                end
            end
            if (state_q == ACCESS) begin
                rdata_q    <= (we_q || err_q) ? '0 : load_ext;
                resp_err_q <= err_q;
            end
        end
    end

    // Reset gates the handshake and the write strobe combinationally so a
    // reset landing in ACCESS never commits a store.
    assign req_ready_o  = (state_q == IDLE) & ~rst_i;
    assign mem_write_o  = (state_q == ACCESS) & we_q & ~err_q & ~rst_i;
    assign mem_be_sel_o = ((state_q == ACCESS) && !err_q) ? be : '0;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = wdata_q;

    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_lsu_data_if.sv
module tb_lsu_data_if;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_write_o;
    logic [3:0]  mem_be_sel_o;
    logic [12:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int checks = 0;
    int errors = 0;

    // data_mem stand-in: byte array, lane k maps to byte addr+k.
    logic [7:0] mem [8192];
    logic       mem_clr;

    always #5 clk = ~clk;

    always_comb begin
        mem_data_i = '0;
        for (int k = 0; k < 4; k++)
            mem_data_i[8*k +: 8] = mem[13'(mem_addr_o + 13'(k))];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h5A;
        end else if (mem_write_o) begin
            for (int k = 0; k < 4; k++)
                if (mem_be_sel_o[k]) mem[13'(mem_addr_o + 13'(k))] <= mem_data_o[8*k +: 8];
        end
    end

    lsu_data_if #(.BASE_ADDR(32'h0001_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_size_i    (req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_rdata_o  (resp_rdata_o),
        .resp_err_o    (resp_err_o),
        .mem_write_o   (mem_write_o),
        .mem_be_sel_o  (mem_be_sel_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i)
    );

    // Observations from the last transaction.
    logic [31:0] rd;
    logic        er;
    logic        aw;
    logic [3:0]  abe;
    logic [12:0] aad;
    logic [31:0] adt;
    logic        quiet;
    logic        ok;

    // Runs one full request/response; ok=0 on any handshake/latency violation.
    task automatic txn(input logic we, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
        ok = 1'b1;
        @(negedge clk);
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = un;
        req_addr_i     = a;
        req_wdata_i    = wd;
        req_valid_i    = 1'b1;
        for (int i = 0; i < 8 && req_ready_o !== 1'b1; i++) @(negedge clk);
        if (req_ready_o !== 1'b1) ok = 1'b0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        aw  = mem_write_o;
        abe = mem_be_sel_o;
        aad = mem_addr_o;
        adt = mem_data_o;
        if (resp_valid_o !== 1'b0) ok = 1'b0;
        @(posedge clk); #1;
        if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0) ok = 1'b0;
        rd    = resp_rdata_o;
        er    = resp_err_o;
        quiet = (mem_write_o === 1'b0) && (mem_be_sel_o === 4'h0);
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        mem_clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready_o !== 1'b0 || mem_write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_gate ready=%b write=%b exp 0 0", req_ready_o, mem_write_o);
        end
        @(posedge clk); #1;
        rst_i   = 1'b0;
        mem_clr = 1'b0;
        #1;
        checks++;
        if ({resp_valid_o, resp_rdata_o, resp_err_o, mem_addr_o, mem_data_o, req_ready_o, mem_be_sel_o}
            !== {1'b0, 32'h0, 1'b0, 13'h0, 32'h0, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL reset_state v=%b rd=%h e=%b a=%h d=%h rdy=%b be=%h exp 0 0 0 0 0 1 0",
                     resp_valid_o, resp_rdata_o, resp_err_o, mem_addr_o, mem_data_o, req_ready_o, mem_be_sel_o);
        end
    endtask

    task automatic test_load_store();
        txn(1'b1, 2'b10, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF);
        checks++;
        if ({ok, er, rd, aw, abe, aad, adt} !== {1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 13'h4, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL st_word ok=%b e=%b rd=%h w=%b be=%h a=%h d=%h exp 1 0 0 1 f 0004 deadbeef",
                     ok, er, rd, aw, abe, aad, adt);
        end
        txn(1'b0, 2'b00, 1'b0, 32'h0001_0007, 32'h0);
        checks++;
        if ({ok, er, rd, aw, abe} !== {1'b1, 1'b0, 32'hFFFF_FFDE, 1'b0, 4'h1}) begin
            errors++;
            $display("FAIL ld_sbyte ok=%b e=%b rd=%h w=%b be=%h exp 1 0 ffffffde 0 1", ok, er, rd, aw, abe);
        end
        txn(1'b0, 2'b01, 1'b1, 32'h0001_0005, 32'h0);
        checks++;
        if ({ok, er, rd, abe} !== {1'b1, 1'b0, 32'h0000_ADBE, 4'h3}) begin
            errors++;
            $display("FAIL ld_uhalf ok=%b e=%b rd=%h be=%h exp 1 0 0000adbe 3", ok, er, rd, abe);
        end
        txn(1'b0, 2'b01, 1'b0, 32'h0001_0005, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'hFFFF_ADBE}) begin
            errors++;
            $display("FAIL ld_shalf ok=%b e=%b rd=%h exp 1 0 ffffadbe", ok, er, rd);
        end
    endtask

    task automatic test_misaligned();
        txn(1'b1, 2'b10, 1'b0, 32'h0001_0001, 32'h1122_3344);
        checks++;
        if ({ok, er, aw, abe, aad, adt} !== {1'b1, 1'b0, 1'b1, 4'hF, 13'h1, 32'h1122_3344}) begin
            errors++;
            $display("FAIL st_misal ok=%b e=%b w=%b be=%h a=%h d=%h exp 1 0 1 f 0001 11223344",
                     ok, er, aw, abe, aad, adt);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h0001_0001, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h1122_3344}) begin
            errors++;
            $display("FAIL ld_misal ok=%b e=%b rd=%h exp 1 0 11223344", ok, er, rd);
        end
        txn(1'b0, 2'b00, 1'b1, 32'h0001_0000, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0000_005A}) begin
            errors++;
            $display("FAIL ld_prev_byte ok=%b e=%b rd=%h exp 1 0 0000005a", ok, er, rd);
        end
    endtask

    task automatic test_boundary();
        txn(1'b1, 2'b01, 1'b0, 32'h0001_1FFE, 32'h0000_A5A5);
        checks++;
        if ({ok, er, aw, abe, aad} !== {1'b1, 1'b0, 1'b1, 4'h3, 13'h1FFE}) begin
            errors++;
            $display("FAIL st_half_edge ok=%b e=%b w=%b be=%h a=%h exp 1 0 1 3 1ffe", ok, er, aw, abe, aad);
        end
        txn(1'b0, 2'b00, 1'b0, 32'h0001_1FFF, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'hFFFF_FFA5}) begin
            errors++;
            $display("FAIL ld_byte_edge ok=%b e=%b rd=%h exp 1 0 ffffffa5", ok, er, rd);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h0001_1FFE, 32'h0);
        checks++;
        if ({ok, er, rd, aw, abe, quiet} !== {1'b1, 1'b1, 32'h0, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL ld_word_over ok=%b e=%b rd=%h w=%b be=%h quiet=%b exp 1 1 0 0 0 1",
                     ok, er, rd, aw, abe, quiet);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h0001_1FFC, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'hA5A5_0000}) begin
            errors++;
            $display("FAIL ld_word_last ok=%b e=%b rd=%h exp 1 0 a5a50000", ok, er, rd);
        end
    endtask

    task automatic test_errors();
        txn(1'b1, 2'b10, 1'b0, 32'h0000_FFFF, 32'hFFFF_FFFF);
        checks++;
        if ({ok, er, rd, aw, abe, quiet} !== {1'b1, 1'b1, 32'h0, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL err_below ok=%b e=%b rd=%h w=%b be=%h quiet=%b exp 1 1 0 0 0 1",
                     ok, er, rd, aw, abe, quiet);
        end
        txn(1'b1, 2'b11, 1'b0, 32'h0001_0004, 32'hFFFF_FFFF);
        checks++;
        if ({ok, er, rd, aw, abe} !== {1'b1, 1'b1, 32'h0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL err_size ok=%b e=%b rd=%h w=%b be=%h exp 1 1 0 0 0", ok, er, rd, aw, abe);
        end
        txn(1'b0, 2'b00, 1'b1, 32'h0002_0000, 32'h0);
        checks++;
        if ({ok, er, rd, abe} !== {1'b1, 1'b1, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL err_above ok=%b e=%b rd=%h be=%h exp 1 1 0 0", ok, er, rd, abe);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h0001_0004, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'hDEAD_BE11}) begin
            errors++;
            $display("FAIL err_no_write ok=%b e=%b rd=%h exp 1 0 deadbe11", ok, er, rd);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = 32'h0001_0004; req_wdata_i = 32'h0;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int i = 0; i < 5 && resp_valid_o !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o} !== {1'b1, 32'hDEAD_BE11, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold c=%0d v=%b rd=%h e=%b rdy=%b exp 1 deadbe11 0 0",
                         c, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o);
            end
            if (c == 1) begin
                req_we_i = 1'b1; req_wdata_i = 32'h0BAD_F00D; req_valid_i = 1'b1;
            end else begin
                req_valid_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        checks++;
        if ({resp_valid_o, req_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release v=%b rdy=%b exp 0 1", resp_valid_o, req_ready_o);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h0001_0004, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'hDEAD_BE11}) begin
            errors++;
            $display("FAIL bp_ignored ok=%b e=%b rd=%h exp 1 0 deadbe11", ok, er, rd);
        end
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = 32'h0001_0010; req_wdata_i = 32'hCAFE_BABE;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        checks++;
        if ({mem_write_o, mem_be_sel_o} !== {1'b1, 4'hF}) begin
            errors++;
            $display("FAIL rst_acc_pre w=%b be=%h exp 1 f", mem_write_o, mem_be_sel_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({mem_write_o, req_ready_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_acc_gate w=%b rdy=%b exp 0 0", mem_write_o, req_ready_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({resp_valid_o, req_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL rst_acc_after v=%b rdy=%b exp 0 1", resp_valid_o, req_ready_o);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0);
        checks++;
        if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_acc_old ok=%b e=%b rd=%h exp 1 0 00000000", ok, er, rd);
        end
    endtask

    initial begin
        rst_i = 1'b1; mem_clr = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; resp_ready_i = 1'b0;
        test_reset();
        test_load_store();
        test_misaligned();
        test_boundary();
        test_errors();
        test_backpressure();
        test_reset_in_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
